// File: rtl/param_stream_pkg.sv
// ---------------------------------------------------------------------------
// param_stream_pkg
// Shared types and sizing helpers for the parameter-stream sink.
//   sink_state_t     : capture state (FILL accepting beats, FULL tensor held)
//   beats_per_tensor : number of beats needed to carry one tensor
//   count_width      : width of a counter that must reach the beat count
//   addr_width       : width of a buffer address (at least 1 bit)
// ---------------------------------------------------------------------------
package param_stream_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } sink_state_t;

  function automatic int beats_per_tensor(input int dim_0, input int dim_1,
                                          input int par_0, input int par_1);
    return (dim_0 * dim_1) / (par_0 * par_1);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/param_sink_ram.sv
// ---------------------------------------------------------------------------
// param_sink_ram
// Simple dual-port beat buffer: one synchronous write port and one read port
// with a two-register read pipeline. Reads are read-first: a read and write of
// the same address on the same edge return the previous contents.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write word
//   rd_en    : read request (sampled at edge T)
//   rd_addr  : read address
//   rd_data  : read word, valid two edges after the request
// The storage has no reset; the read pipeline registers are data-only.
// ---------------------------------------------------------------------------
module param_sink_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int WIDTH  = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_p1;
  logic [WIDTH-1:0] rd_data_p2;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    // ---- stage p1: array read (non-blocking, so old contents win)
    if (rd_en) begin
      rd_data_p1 <= mem[rd_addr];
    end
    // ---- stage p2: output register
    rd_data_p2 <= rd_data_p1;
  end

  assign rd_data = rd_data_p2;

endmodule

// File: rtl/param_stream_sink.sv
// ---------------------------------------------------------------------------
// param_stream_sink
// Capture endpoint of the parameter-stream interface. Accepts IN_DEPTH beats
// over valid/ready, stores them in order, reports completion, and offers a
// read-back port with the same 2-cycle latency as the parameter ROMs.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   data_in       : beat elements (PAR_0*PAR_1 words of BIAS_PRECISION_0 bits)
//   data_in_valid : beat present
//   data_in_ready : sink accepts (high only while filling)
//   clear         : synchronous restart of capture, buffer contents retained
//   done          : all IN_DEPTH beats captured
//   overflow      : sticky, valid presented while full
//   beat_count    : beats accepted since reset/clear
//   rd_en/rd_addr : read-back request and beat index
//   rd_data       : flattened beat, element j at bits [W*j +: W]; 0 when the
//                   address is beyond the tensor
//   rd_valid      : rd_en delayed by two cycles
// ---------------------------------------------------------------------------
module param_stream_sink
  import param_stream_pkg::*;
#(
  parameter int BIAS_TENSOR_SIZE_DIM_0 = 32,
  parameter int BIAS_TENSOR_SIZE_DIM_1 = 1,
  parameter int BIAS_PRECISION_0       = 16,
  parameter int BIAS_PRECISION_1       = 3,
  parameter int BIAS_PARALLELISM_DIM_0 = 1,
  parameter int BIAS_PARALLELISM_DIM_1 = 1,
  parameter int IN_DEPTH      = beats_per_tensor(BIAS_TENSOR_SIZE_DIM_0, BIAS_TENSOR_SIZE_DIM_1,
                                                 BIAS_PARALLELISM_DIM_0, BIAS_PARALLELISM_DIM_1),
  parameter int COUNTER_WIDTH = count_width(IN_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BIAS_PRECISION_0-1:0] data_in [BIAS_PARALLELISM_DIM_0*BIAS_PARALLELISM_DIM_1],
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  input  logic                        clear,
  output logic                        done,
  output logic                        overflow,
  output logic [COUNTER_WIDTH-1:0]    beat_count,
  input  logic                        rd_en,
  input  logic [COUNTER_WIDTH-1:0]    rd_addr,
  output logic [BIAS_PRECISION_0*BIAS_PARALLELISM_DIM_0*BIAS_PARALLELISM_DIM_1-1:0] rd_data,
  output logic                        rd_valid
);

  localparam int PAR    = BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1;
  localparam int BEAT_W = BIAS_PRECISION_0 * PAR;
  localparam int ADDR_W = addr_width(IN_DEPTH);

  // Fractional bits only travel with the data; a nonsensical value is caught
  // at elaboration.
  if (BIAS_PRECISION_1 > BIAS_PRECISION_0) begin : g_frac_check
    $error("BIAS_PRECISION_1 exceeds BIAS_PRECISION_0");
  end

  sink_state_t       state;
  logic [BEAT_W-1:0] wr_beat;
  logic              wr_en;
  logic              last_beat;
  logic              in_range;
  logic [BEAT_W-1:0] ram_q;
  logic              vld_p1;
  logic              vld_p2;
  logic              inrng_p1;
  logic              inrng_p2;

  always_comb begin
    wr_beat = '0;
    for (int j = 0; j < PAR; j++) begin
      wr_beat[BIAS_PRECISION_0*j +: BIAS_PRECISION_0] = data_in[j];
    end
  end

  // Ready depends only on state; it is also held low while reset is asserted.
  assign data_in_ready = rst_n && (state == FILL);
  // Clear wins over a coincident handshake: nothing is written or counted.
  assign wr_en     = data_in_valid && data_in_ready && !clear;
  assign last_beat = (beat_count == COUNTER_WIDTH'(IN_DEPTH - 1));
  assign in_range  = (rd_addr < COUNTER_WIDTH'(IN_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      beat_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else if (clear) begin
      state      <= FILL;
      beat_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (data_in_valid) begin
            beat_count <= beat_count + 1'b1;
            if (last_beat) begin
              state <= FULL;
              done  <= 1'b1;
            end
          end
        end
        FULL: begin
          if (data_in_valid) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
          done  <= 1'b0;
        end
      endcase
    end
  end

  param_sink_ram #(
    .DEPTH  (IN_DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (BEAT_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (beat_count[ADDR_W-1:0]),
    .wr_data (wr_beat),
    .rd_en   (rd_en),
    .rd_addr (rd_addr[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      inrng_p1 <= 1'b0;
      vld_p2   <= 1'b0;
      inrng_p2 <= 1'b0;
    end else begin
      // ---- stage p1: request and range flag alongside the array read
      vld_p1   <= rd_en;
      inrng_p1 <= rd_en && in_range;
      // ---- stage p2: aligned with the RAM output register
      vld_p2   <= vld_p1;
      inrng_p2 <= inrng_p1;
    end
  end

  assign rd_valid = vld_p2;
  assign rd_data  = inrng_p2 ? ram_q : '0;

endmodule

// File: tb/tb_param_stream_sink.sv
module tb_param_stream_sink;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: defaults (32 beats of one element)
  logic [W-1:0] a_din [1];
  logic         a_valid, a_ready, a_clear, a_done, a_ovf, a_rd_en, a_rd_valid;
  logic [5:0]   a_cnt, a_rd_addr;
  logic [15:0]  a_rd_data;

  // Instance B: PAR_0 = 4 (8 beats of four elements)
  logic [W-1:0] b_din [4];
  logic         b_valid, b_ready, b_clear, b_done, b_ovf, b_rd_en, b_rd_valid;
  logic [3:0]   b_cnt, b_rd_addr;
  logic [63:0]  b_rd_data;

  param_stream_sink dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_din), .data_in_valid(a_valid),
    .data_in_ready(a_ready), .clear(a_clear), .done(a_done), .overflow(a_ovf),
    .beat_count(a_cnt), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  param_stream_sink #(.BIAS_PARALLELISM_DIM_0(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_din), .data_in_valid(b_valid),
    .data_in_ready(b_ready), .clear(b_clear), .done(b_done), .overflow(b_ovf),
    .beat_count(b_cnt), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } rd_exp_t;

  rd_exp_t     qa[$];
  rd_exp_t     qb[$];
  logic [15:0] a_mem [32];
  logic [63:0] b_mem [8];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for read-back of A: data and arrival cycle
  always @(negedge clk) begin
    if (a_rd_valid === 1'b1) begin
      n_checks++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_rd_unexpected: rd_valid=1 rd_data=%h with no read outstanding (cycle %0d)", a_rd_data, cyc);
      end else begin
        rd_exp_t e;
        e = qa.pop_front();
        if (a_rd_data !== e.data[15:0] || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL a_rd_data: got %h at cycle %0d, expected %h at cycle %0d", a_rd_data, cyc, e.data[15:0], e.cyc);
        end
      end
    end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
      rd_exp_t e;
      e = qa.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL a_rd_missing: rd_valid=%b at cycle %0d, expected 1 with data %h", a_rd_valid, cyc, e.data[15:0]);
    end
  end

  // Scoreboard for read-back of B
  always @(negedge clk) begin
    if (b_rd_valid === 1'b1) begin
      n_checks++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_rd_unexpected: rd_valid=1 rd_data=%h with no read outstanding (cycle %0d)", b_rd_data, cyc);
      end else begin
        rd_exp_t e;
        e = qb.pop_front();
        if (b_rd_data !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL b_rd_data: got %h at cycle %0d, expected %h at cycle %0d", b_rd_data, cyc, e.data, e.cyc);
        end
      end
    end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
      rd_exp_t e;
      e = qb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL b_rd_missing: rd_valid=%b at cycle %0d, expected 1 with data %h", b_rd_valid, cyc, e.data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  // Drive one beat into A for one edge (back-to-back calls keep valid high).
  task automatic send_a(input logic [15:0] v);
    a_din[0] = v;
    a_valid  = 1'b1;
    @(posedge clk); #1;
    a_valid  = 1'b0;
  endtask

  task automatic read_a(input logic [5:0] addr, input logic [15:0] exp);
    a_rd_en   = 1'b1;
    a_rd_addr = addr;
    qa.push_back('{data: {48'd0, exp}, cyc: cyc + 2});
    @(posedge clk); #1;
    a_rd_en   = 1'b0;
  endtask

  task automatic read_b(input logic [3:0] addr, input logic [63:0] exp);
    b_rd_en   = 1'b1;
    b_rd_addr = addr;
    qb.push_back('{data: exp, cyc: cyc + 2});
    @(posedge clk); #1;
    b_rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; a_clear = 1'b0; a_rd_en = 1'b0; a_rd_addr = '0; a_din[0] = '0;
    b_valid = 1'b0; b_clear = 1'b0; b_rd_en = 1'b0; b_rd_addr = '0;
    for (int j = 0; j < 4; j++) b_din[j] = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (a_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", a_ready); end
    n_checks++; if (a_done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b, expected 0", a_done); end
    n_checks++; if (a_ovf !== 1'b0)     begin n_fail++; $display("FAIL reset_overflow: got %b, expected 0", a_ovf); end
    n_checks++; if (a_cnt !== 6'd0)     begin n_fail++; $display("FAIL reset_beat_count: got %0d, expected 0", a_cnt); end
    n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b, expected 0", a_rd_valid); end
    n_checks++; if (a_rd_data !== 16'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h, expected 0", a_rd_data); end
    #2 rst_n = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_a: got %b, expected 1", a_ready); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_b: got %b, expected 1", b_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (a_done !== 1'b0 || a_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_early_done: before beat %0d done=%b ready=%b, expected done=0 ready=1", k, a_done, a_ready);
      end
      send_a(16'(k + 1));
      a_mem[k] = 16'(k + 1);
    end
    n_checks++; if (a_done !== 1'b1)  begin n_fail++; $display("FAIL fill_done: got %b, expected 1", a_done); end
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b, expected 0", a_ready); end
    n_checks++; if (a_cnt !== 6'd32)  begin n_fail++; $display("FAIL fill_beat_count: got %0d, expected 32", a_cnt); end
    n_checks++; if (a_ovf !== 1'b0)   begin n_fail++; $display("FAIL fill_overflow: got %b, expected 0", a_ovf); end
    for (int k = 0; k < 32; k++) read_a(6'(k), a_mem[k]);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL fill_drain: %0d reads outstanding, expected 0", qa.size()); end
  endtask

  task automatic test_overflow();
    a_din[0] = 16'hBEEF;
    a_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_valid  = 1'b0;
    n_checks++; if (a_ovf !== 1'b1)  begin n_fail++; $display("FAIL ovf_set: got %b, expected 1", a_ovf); end
    n_checks++; if (a_cnt !== 6'd32) begin n_fail++; $display("FAIL ovf_beat_count: got %0d, expected 32", a_cnt); end
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL ovf_done: got %b, expected 1", a_done); end
    read_a(6'd0, a_mem[0]);
    read_a(6'd15, a_mem[15]);
    read_a(6'd31, a_mem[31]);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL ovf_drain: %0d reads outstanding, expected 0", qa.size()); end
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    n_checks++; if (a_ovf !== 1'b0)   begin n_fail++; $display("FAIL clear_overflow: got %b, expected 0", a_ovf); end
    n_checks++; if (a_cnt !== 6'd0)   begin n_fail++; $display("FAIL clear_beat_count: got %0d, expected 0", a_cnt); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready: got %b, expected 1", a_ready); end
    n_checks++; if (a_done !== 1'b0)  begin n_fail++; $display("FAIL clear_done: got %b, expected 0", a_done); end
  endtask

  task automatic test_clear_coincident();
    for (int k = 0; k < 4; k++) begin
      send_a(16'h0100 + 16'(k));
      a_mem[k] = 16'h0100 + 16'(k);
    end
    n_checks++; if (a_cnt !== 6'd4) begin n_fail++; $display("FAIL cc_count4: got %0d, expected 4", a_cnt); end
    a_clear = 1'b1;
    send_a(16'h5555);
    a_clear = 1'b0;
    n_checks++; if (a_cnt !== 6'd0) begin n_fail++; $display("FAIL cc_count0: got %0d, expected 0", a_cnt); end
    send_a(16'h0A0A);
    a_mem[0] = 16'h0A0A;
    n_checks++; if (a_cnt !== 6'd1) begin n_fail++; $display("FAIL cc_count1: got %0d, expected 1", a_cnt); end
    read_a(6'd0, a_mem[0]);
    read_a(6'd1, a_mem[1]);
    read_a(6'd4, a_mem[4]);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL cc_drain: %0d reads outstanding, expected 0", qa.size()); end
  endtask

  task automatic test_async_reset();
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    for (int k = 0; k < 10; k++) begin
      send_a(16'h0200 + 16'(k));
      a_mem[k] = 16'h0200 + 16'(k);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b0)    begin n_fail++; $display("FAIL ares_ready: got %b, expected 0", a_ready); end
    n_checks++; if (a_cnt !== 6'd0)      begin n_fail++; $display("FAIL ares_beat_count: got %0d, expected 0", a_cnt); end
    n_checks++; if (a_done !== 1'b0)     begin n_fail++; $display("FAIL ares_done: got %b, expected 0", a_done); end
    n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL ares_rd_valid: got %b, expected 0", a_rd_valid); end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL ares_release_ready: got %b, expected 1", a_ready); end
    send_a(16'h3333);
    a_mem[0] = 16'h3333;
    n_checks++; if (a_cnt !== 6'd1) begin n_fail++; $display("FAIL ares_refill_count: got %0d, expected 1", a_cnt); end
    read_a(6'd0, a_mem[0]);
    read_a(6'd1, a_mem[1]);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL ares_drain: %0d reads outstanding, expected 0", qa.size()); end
  endtask

  task automatic test_read_first();
    for (int k = 1; k < 7; k++) begin
      send_a(16'h0400 + 16'(k));
      a_mem[k] = 16'h0400 + 16'(k);
    end
    n_checks++; if (a_cnt !== 6'd7) begin n_fail++; $display("FAIL rf_count: got %0d, expected 7", a_cnt); end
    // write of beat 7 and read of address 7 on the same edge
    a_din[0]  = 16'h7777;
    a_valid   = 1'b1;
    a_rd_en   = 1'b1;
    a_rd_addr = 6'd7;
    qa.push_back('{data: {48'd0, a_mem[7]}, cyc: cyc + 2});
    @(posedge clk); #1;
    a_valid   = 1'b0;
    a_mem[7]  = 16'h7777;
    read_a(6'd7, a_mem[7]);
    read_a(6'd40, 16'h0000);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL rf_drain: %0d reads outstanding, expected 0", qa.size()); end
  endtask

  task automatic test_par4_gaps();
    for (int k = 0; k < 8; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      n_checks++;
      if (b_done !== 1'b0 || b_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL par4_early_done: before beat %0d done=%b ready=%b, expected done=0 ready=1", k, b_done, b_ready);
      end
      for (int j = 0; j < 4; j++) b_din[j] = 16'($urandom);
      b_mem[k] = {b_din[3], b_din[2], b_din[1], b_din[0]};
      b_valid  = 1'b1;
      @(posedge clk); #1;
      b_valid  = 1'b0;
    end
    n_checks++; if (b_done !== 1'b1) begin n_fail++; $display("FAIL par4_done: got %b, expected 1", b_done); end
    n_checks++; if (b_cnt !== 4'd8)  begin n_fail++; $display("FAIL par4_beat_count: got %0d, expected 8", b_cnt); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL par4_ready: got %b, expected 0", b_ready); end
    for (int k = 0; k < 8; k++) read_b(4'(k), b_mem[k]);
    read_b(4'd9, 64'd0);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (qb.size() != 0) begin n_fail++; $display("FAIL par4_drain: %0d reads outstanding, expected 0", qb.size()); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_clear_coincident();
    test_async_reset();
    test_read_first();
    test_par4_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
